// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide, one result bit per clock.
// A shift-add multiplier and a restoring divider share one datapath; *W ops iterate WORD_WIDTH times.
module mul_div_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int WORD_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [CONTROL_WIDTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0]    i_src_1,
    input  logic [DATA_WIDTH-1:0]    i_src_2,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic                     o_busy
);
    localparam int DW = DATA_WIDTH;
    localparam int WW = WORD_WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            is_div, want_rem, want_high, word, negate;
    logic [2*DW-1:0] a_reg, acc;
    logic [DW-1:0]   b_reg;

    function automatic logic [DW-1:0] word_ext(input logic [DW-1:0] v, input logic w);
        return w ? {{(DW-WW){v[WW-1]}}, v[WW-1:0]} : v;
    endfunction

    // Request decode
    logic d_mul, d_div, d_word, d_s1, d_s2, d_rem, d_high;
    always_comb begin
        d_mul = 1'b0; d_div = 1'b0; d_word = 1'b0;
        d_s1 = 1'b0; d_s2 = 1'b0; d_rem = 1'b0; d_high = 1'b0;
        case (32'(i_op))
            0:  d_mul = 1'b1;
            1:  begin d_mul = 1'b1; d_high = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            2:  begin d_mul = 1'b1; d_high = 1'b1; d_s1 = 1'b1; end
            3:  begin d_mul = 1'b1; d_high = 1'b1; end
            4:  begin d_div = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            5:  d_div = 1'b1;
            6:  begin d_div = 1'b1; d_rem = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            7:  begin d_div = 1'b1; d_rem = 1'b1; end
            8:  begin d_mul = 1'b1; d_word = 1'b1; end
            9:  begin d_div = 1'b1; d_word = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            10: begin d_div = 1'b1; d_word = 1'b1; end
            11: begin d_div = 1'b1; d_word = 1'b1; d_rem = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            12: begin d_div = 1'b1; d_word = 1'b1; d_rem = 1'b1; end
            default: ;
        endcase
    end

    // Operands extended from N bits per signedness, then reduced to magnitudes
    logic [DW-1:0] x1, x2, m1, m2, min_val;
    logic          sg1, sg2, div_zero, div_ovf;
    always_comb begin
        x1 = i_src_1;
        x2 = i_src_2;
        if (d_word) begin
            x1 = d_s1 ? word_ext(i_src_1, 1'b1) : {{(DW-WW){1'b0}}, i_src_1[WW-1:0]};
            x2 = d_s2 ? word_ext(i_src_2, 1'b1) : {{(DW-WW){1'b0}}, i_src_2[WW-1:0]};
        end
        sg1      = d_s1 & x1[DW-1];
        sg2      = d_s2 & x2[DW-1];
        m1       = sg1 ? -x1 : x1;
        m2       = sg2 ? -x2 : x2;
        min_val  = d_word ? ({DW{1'b1}} << (WW-1)) : ({DW{1'b1}} << (DW-1));
        div_zero = d_div & (x2 == '0);
        div_ovf  = d_div & d_s1 & d_s2 & (x1 == min_val) & (x2 == '1);
    end

    // One iteration step; the result is formed from the step outputs so the last
    // iteration and the result register update share one edge.
    logic [2*DW-1:0] acc_nxt, a_nxt, prod;
    logic [DW-1:0]   b_nxt, quo_rem, raw, calc_result;
    logic [DW:0]     rs, diff;
    logic            ge;
    always_comb begin
        rs   = {acc[DW-1:0], a_reg[DW-1]};
        diff = rs - {1'b0, b_reg};
        ge   = (rs >= {1'b0, b_reg});
        if (is_div) begin
            acc_nxt = {{(DW-1){1'b0}}, (ge ? diff : rs)};
            a_nxt   = {a_reg[2*DW-2:0], ge};
            b_nxt   = b_reg;
        end else begin
            acc_nxt = b_reg[0] ? acc + a_reg : acc;
            a_nxt   = a_reg << 1;
            b_nxt   = b_reg >> 1;
        end
        prod    = negate ? -acc_nxt : acc_nxt;
        quo_rem = want_rem ? acc_nxt[DW-1:0] : a_nxt[DW-1:0];
        if (negate)
            quo_rem = -quo_rem;
        raw = is_div ? quo_rem : (want_high ? prod[2*DW-1:DW] : prod[DW-1:0]);
        calc_result = word_ext(raw, word);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= IDLE;
            count     <= '0;
            o_result  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            is_div    <= 1'b0;
            want_rem  <= 1'b0;
            want_high <= 1'b0;
            word      <= 1'b0;
            negate    <= 1'b0;
        end else if (i_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    is_div    <= d_div;
                    want_rem  <= d_rem;
                    want_high <= d_high;
                    word      <= d_word;
                    negate    <= d_rem ? sg1 : (sg1 ^ sg2);
                    count     <= d_word ? CW'(WW-1) : CW'(DW-1);
                    // Divider consumes dividend MSB-first, so align the N-bit value to the top
                    a_reg     <= {{DW{1'b0}}, ((d_div && d_word) ? (m1 << (DW-WW)) : m1)};
                    b_reg     <= m2;
                    acc       <= '0;
                    if (!(d_mul || d_div)) begin
                        o_result <= '0;
                        state    <= DONE;
                    end else if (div_zero) begin
                        o_result <= d_rem ? word_ext(i_src_1, d_word) : '1;
                        state    <= DONE;
                    end else if (div_ovf) begin
                        o_result <= d_rem ? '0 : word_ext(i_src_1, d_word);
                        state    <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= a_nxt;
                    b_reg <= b_nxt;
                    acc   <= acc_nxt;
                    if (count == '0) begin
                        o_result <= calc_result;
                        state    <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: if (i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state != IDLE);
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed RV64M corner cases plus random ops against an
// arithmetic reference model, with latency, handshake, flush and reset checks.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_op = '0;
    logic [63:0] i_src_1 = '0;
    logic [63:0] i_src_2 = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [63:0] o_result;
    logic        o_busy;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    mul_div_unit dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_src_1(i_src_1), .i_src_2(i_src_2), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RV64M semantics computed with wide native arithmetic
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        logic signed [63:0]  s64a, s64b, q64;
        logic signed [31:0]  s32a, s32b, q32;
        logic [31:0]         a32, b32, r32;
        sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
        ua = {64'b0, a};       ub = {64'b0, b};
        s64a = a; s64b = b;
        a32 = a[31:0]; b32 = b[31:0];
        s32a = a32; s32b = b32;
        case (op)
            4'd0: return a * b;
            4'd1: begin p = sa * sb; return p[127:64]; end
            4'd2: begin p = sa * ub; return p[127:64]; end
            4'd3: begin p = ua * ub; return p[127:64]; end
            4'd4: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return a;
                q64 = s64a / s64b; return q64;
            end
            4'd5: return (b == 0) ? '1 : a / b;
            4'd6: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return '0;
                q64 = s64a % s64b; return q64;
            end
            4'd7: return (b == 0) ? a : a % b;
            4'd8: begin r32 = a32 * b32; return sx32(r32); end
            4'd9: begin
                if (b32 == 0) return '1;
                if (a32 == 32'h8000_0000 && b32 == '1) return sx32(a32);
                q32 = s32a / s32b; return sx32(q32);
            end
            4'd10: begin r32 = (b32 == 0) ? '1 : a32 / b32; return sx32(r32); end
            4'd11: begin
                if (b32 == 0) return sx32(a32);
                if (a32 == 32'h8000_0000 && b32 == '1) return '0;
                q32 = s32a % s32b; return sx32(q32);
            end
            4'd12: begin r32 = (b32 == 0) ? a32 : a32 % b32; return sx32(r32); end
            default: return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic is_w, sdiv;
        if (op > 4'd12) return 1;
        is_w = (op >= 4'd8);
        sdiv = (op == 4'd4) || (op == 4'd6) || (op == 4'd9) || (op == 4'd11);
        if ((op >= 4'd4 && op <= 4'd7) || op >= 4'd9) begin
            if (is_w ? (b[31:0] == 0) : (b == 0)) return 1;
            if (sdiv && !is_w && a == MIN64 && b == '1) return 1;
            if (sdiv && is_w && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
        end
        return is_w ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return MIN64;
            3: return 64'($urandom_range(0, 9));
            4: return {$urandom, 32'h8000_0000};
            5: return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Starts and ends at a negedge with the unit idle; the result is taken by the last edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int hold);
        int lat;
        logic [63:0] held;
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
        i_valid = 1'b1; i_op = op; i_src_1 = a; i_src_2 = b;
        @(negedge clk);
        i_valid = 1'b0; i_op = 4'($urandom); i_src_1 = {$urandom, $urandom}; i_src_2 = {$urandom, $urandom};
        chk({tag, "_busy"}, {62'd0, o_ready, o_busy}, 64'd1);
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
        chk({tag, "_res"}, o_result, exp);
        held = o_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {o_valid, o_result}, {1'b1, held});
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;

        #1;
        chk("rst_vals", {o_ready, o_valid, o_busy, o_result}, {3'b100, 64'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mulhu",  4'd3, '1, 64'd2, 64'd1, 0);
        run_op("mul",    4'd0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("div",    4'd4, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem",    4'd6, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("divu0",  4'd5, 64'd1234, 64'd0, '1, 0);
        run_op("rem0",   4'd6, 64'd5, 64'd0, 64'd5, 0);
        run_op("divovf", 4'd4, MIN64, '1, MIN64, 0);
        run_op("divwovf", 4'd9, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
        run_op("mulw",   4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("mulwg",  4'd8, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("remuw0", 4'd12, 64'h0000_0000_9000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_9000_0001, 0);
        run_op("undef",  4'd14, 64'd77, 64'd3, 64'd0, 0);
        run_op("bp",     4'd1, 64'h1234_5678_9ABC_DEF0, -64'sd3, ref_res(4'd1, 64'h1234_5678_9ABC_DEF0, -64'sd3), 10);
        run_op("b2b",    4'd7, 64'd100, 64'd7, 64'd2, 0);

        // Flush at iteration 20 with a competing request in the same cycle
        i_valid = 1'b1; i_op = 4'd0; i_src_1 = 64'd3; i_src_2 = 64'd5;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (20) @(negedge clk);
        i_flush = 1'b1; i_valid = 1'b1; i_op = 4'd5; i_src_1 = 64'd9; i_src_2 = 64'd3;
        @(negedge clk);
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_state", {61'd0, o_ready, o_valid, o_busy}, 64'b100);
        watch_no_valid("flush_quiet", 70);
        run_op("mulhsu", 4'd2, '1, 64'd1, '1, 0);

        // Asynchronous reset mid-calculation
        i_valid = 1'b1; i_op = 4'd3; i_src_1 = '1; i_src_2 = '1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {o_ready, o_valid, o_busy, o_result}, {3'b100, 64'd0});
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("rst_quiet", 70);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, ref_res(op, a, b), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV64M multiply/divide unit, the multi-cycle companion to the single-cycle integer ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and computes the result with a radix-2 shift-add multiplier or restoring divider. It then holds the result until the pipeline takes it. Width is parametrised, and word (`*W`) variants operate on the low `WORD_WIDTH` bits with sign extension.

## Interface
- `DATA_WIDTH`, default 64: operand and result width.
- `WORD_WIDTH`, default 32: width used by `*W` operations; must be less than `DATA_WIDTH`.
- `CONTROL_WIDTH`, default 4: width of the operation code.
- `i_clk` in 1: clock. One clock domain.
- `i_arst_n` in 1: reset. Asynchronous, active-low.
- `i_valid` in 1: request valid.
- `o_ready` out 1: unit idle and able to accept a request.
- `i_op` in `CONTROL_WIDTH`: operation code, sampled on accept.
  - 0 `MUL`, 1 `MULH`, 2 `MULHSU`, 3 `MULHU`
  - 4 `DIV`, 5 `DIVU`, 6 `REM`, 7 `REMU`
  - 8 `MULW`, 9 `DIVW`, 10 `DIVUW`, 11 `REMW`, 12 `REMUW`
- `i_src_1` in `DATA_WIDTH`: rs1 operand, sampled on accept.
- `i_src_2` in `DATA_WIDTH`: rs2 operand, sampled on accept.
- `i_flush` in 1: abort the current operation and return to `IDLE`.
- `o_valid` out 1: result valid.
- `i_ready` in 1: consumer takes the result.
- `o_result` out `DATA_WIDTH`: result, stable while `o_valid` is high.
- `o_busy` out 1: high in `CALC` or `DONE`.

## Operation
- **States.**
  - `IDLE`: `o_ready` is 1.
  - `CALC`: iterating.
  - `DONE`: `o_valid` is 1.
- **Accept.** A request is accepted when `i_valid & o_ready` at a clock edge. Operands and op are latched; the operand width N is set to `WORD_WIDTH` for op 8–12, otherwise `DATA_WIDTH`.
- **Signed handling.** Operands are converted to magnitudes per the op's signedness, with a latched result-negate flag.
  - `MULHSU`: only rs1 is signed.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- **Multiply.** 2N-bit accumulator, one bit per cycle, N cycles. `MUL`/`MULW` return the low N bits; the `MULH*` ops return the high N bits after sign correction of the full 2N-bit product.
- **Divide.** Restoring division, one quotient bit per cycle, N cycles.
- **Fast path** (`IDLE` → `DONE` directly, no `CALC`):
  - **Divide by zero:** quotient is all ones (N bits); remainder is rs1 (N bits).
  - **Signed overflow** (rs1 = most-negative N-bit value, rs2 = −1): quotient is rs1 (N bits); remainder is 0.
  - **Undefined op** (13–15): result 0.
- **W ops.** The N-bit result is sign-extended from bit `WORD_WIDTH-1` to `DATA_WIDTH`. This applies to `DIVUW`/`REMUW` as well, per RV64M.
- **Iteration counter.** Counts N−1 down to 0. The transition `CALC` → `DONE` happens on the edge where the counter is 0.
- **Result handoff.** `DONE` → `IDLE` on `o_valid & i_ready`. `o_result` and `o_valid` hold until then.
- **Flush.** `i_flush` has priority over everything, in any state.
  - Next state is `IDLE`; `o_valid` is deasserted the next cycle; the result is discarded.
  - A request presented in the same cycle as `i_flush` is not accepted.

## Timing
- **Reset values** (asynchronous, while `i_arst_n` = 0): state `IDLE`, `o_ready` 1, `o_valid` 0, `o_busy` 0, `o_result` 0, counter 0.
- **Reset mid-operation** aborts immediately. No result is produced after release.
- **Latency, accept edge to first cycle of `o_valid`:**
  - 64-bit ops: N+1 cycles, i.e. 65 edges.
  - W ops: 33 edges.
  - Fast path: 1 cycle.
- **Ready and back-to-back.** `o_ready` is low from the cycle after accept until the cycle after the result is taken. `o_ready` is combinational from state only, with no dependence on `i_valid`. A new request may be accepted in the cycle immediately after `o_valid & i_ready`.
- **Throughput:** one operation per N+2 cycles when the consumer is always ready.
- **Ignored inputs.** `i_op` and the sources are ignored outside the accept cycle. `i_ready` is ignored when `o_valid` is 0.

## Test plan
- **Unsigned multiply.** `MULHU` with rs1 = 0xFFFF_FFFF_FFFF_FFFF, rs2 = 2 → `o_result` = 0x1 after 65 edges. `MUL` on the same operands → 0xFFFF_FFFF_FFFF_FFFE.
- **Signed divide/remainder.** `DIV` with rs1 = −7, rs2 = 2 → 0xFFFF_FFFF_FFFF_FFFD (−3). `REM` on the same operands → 0xFFFF_FFFF_FFFF_FFFF (−1).
- **Fast-path corner cases, checked for 1-cycle latency:**
  - `DIVU` by 0 → all ones.
  - `REM` by 0 with rs1 = 5 → 5.
  - `DIV` with 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000.
  - `DIVW` with 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- **Word multiply.** `MULW` with rs1 = 0x7FFF_FFFF, rs2 = 2 → 0xFFFF_FFFF_FFFF_FFFE after 33 edges. Upper input bits set to garbage must not change the result.
- **Handshake backpressure.** Hold `i_ready` = 0 for 10 cycles in `DONE`: `o_result` stable and `o_valid` held. Then take the result and issue the next request in the following cycle: it is accepted.
- **Flush and reset.**
  - `i_flush` at iteration 20 → `IDLE` next cycle with no `o_valid`; a following `MULHSU` with −1 × 1 → 0xFFFF_FFFF_FFFF_FFFF.
  - Assert `i_arst_n` = 0 mid-`CALC` → all outputs at their reset values immediately.
